// File: rtl/idex_ctrl_pipe.sv
// idex_ctrl_pipe: ID/EX control-word register with programmable hazard bubble insertion.
// Optional bubble statistics counter (bubble_cnt_o) enabled by defining IDEX_STATS_EN.
module idex_ctrl_pipe #(
  parameter int WB_W = 2,
  parameter int MEM_W = 3,
  parameter int EX_W = 4,
  parameter int BUBBLE_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [WB_W+MEM_W+EX_W-1:0] ctrl_i,
  input  logic valid_i,
  input  logic hd_i,
  input  logic stall_i,
  input  logic flush_i,
  output logic [WB_W-1:0] wb_o,
  output logic [MEM_W-1:0] mem_o,
  output logic [EX_W-1:0] ex_o,
  output logic valid_o,
  output logic bubble_o,
  output logic busy_o
`ifdef IDEX_STATS_EN
  ,output logic [CNT_W-1:0] bubble_cnt_o
`endif
);
  localparam int TOP = WB_W+MEM_W+EX_W-1;
  localparam int BW = $clog2(BUBBLE_CYCLES+1);
  typedef enum logic {IDLE, BUBBLE} state_t;
  state_t state;
  logic [BW-1:0] bcnt;
  logic ins;
  assign ins = ~flush_i & ~stall_i & ((state == BUBBLE) | (hd_i & valid_i));
  assign busy_o = ~flush_i & ((state == BUBBLE) | (hd_i & valid_i & ~stall_i));
  // Control-word register and bubble sequencer: flush kills, stall holds, hazard inserts bubbles.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state <= IDLE;
      bcnt <= '0;
      wb_o <= '0;
      mem_o <= '0;
      ex_o <= '0;
      valid_o <= 1'b0;
      bubble_o <= 1'b0;
    end else if (!stall_i) begin
      if (ins) begin
        wb_o <= '0;
        mem_o <= '0;
        ex_o <= '0;
        valid_o <= 1'b0;
        bubble_o <= 1'b1;
        if (state == IDLE) begin
          if (BUBBLE_CYCLES > 1) begin
            state <= BUBBLE;
            bcnt <= BW'(BUBBLE_CYCLES-1);
          end
        end else begin
          bcnt <= bcnt - 1'b1;
          if (bcnt == BW'(1)) state <= IDLE;
        end
      end else begin
        wb_o <= ctrl_i[TOP:MEM_W+EX_W];
        mem_o <= ctrl_i[MEM_W+EX_W-1:EX_W];
        ex_o <= ctrl_i[EX_W-1:0];
        valid_o <= valid_i;
        bubble_o <= 1'b0;
      end
    end
  end
`ifdef IDEX_STATS_EN
  // Saturating count of inserted bubbles; survives flush, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) bubble_cnt_o <= '0;
    else if (ins && !(&bubble_cnt_o)) bubble_cnt_o <= bubble_cnt_o + 1'b1;
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif
endmodule

// File: tb/tb_idex_ctrl_pipe.sv
// tb_idex_ctrl_pipe: random and directed checks of idex_ctrl_pipe (1 and 3 bubbles) against a bubble-debt model.
module tb_idex_ctrl_pipe;
  logic clk = 1'b0;
  logic rst, valid, hd, stall, flush;
  logic [8:0] ctrl;
  logic [1:0] wb [2];
  logic [2:0] mem [2];
  logic [3:0] ex [2];
  logic vo [2];
  logic bo [2];
  logic busy [2];
`ifdef IDEX_STATS_EN
  logic [3:0] cnt [2];
`endif
  int bc [2] = '{1, 3};
  int rem [2];
  int mcnt [2];
  logic [8:0] mc [2];
  logic mv [2];
  logic mb [2];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gd
    idex_ctrl_pipe #(.BUBBLE_CYCLES(g == 0 ? 1 : 3), .CNT_W(4)) dut (
      .clk_i(clk), .rst_i(rst), .ctrl_i(ctrl), .valid_i(valid), .hd_i(hd),
      .stall_i(stall), .flush_i(flush), .wb_o(wb[g]), .mem_o(mem[g]), .ex_o(ex[g]),
      .valid_o(vo[g]), .bubble_o(bo[g]), .busy_o(busy[g])
`ifdef IDEX_STATS_EN
      ,.bubble_cnt_o(cnt[g])
`endif
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic [8:0] c, input logic v, input logic h, input logic s, input logic f);
    rst = r; ctrl = c; valid = v; hd = h; stall = s; flush = f;
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("busy_bc%0d", bc[i]), 32'(busy[i]), 32'(!f && (rem[i] > 0 || (h && v && !s))));
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r || f) begin
        mc[i] = '0; mv[i] = 1'b0; mb[i] = 1'b0; rem[i] = 0;
        if (r) mcnt[i] = 0;
      end else if (!s) begin
        if (rem[i] > 0 || (h && v)) begin
          mc[i] = '0; mv[i] = 1'b0; mb[i] = 1'b1;
          rem[i] = rem[i] > 0 ? rem[i] - 1 : bc[i] - 1;
          if (mcnt[i] < 15) mcnt[i]++;
        end else begin
          mc[i] = c; mv[i] = v; mb[i] = 1'b0;
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("wb_bc%0d", bc[i]), 32'(wb[i]), 32'(mc[i][8:7]));
      check($sformatf("mem_bc%0d", bc[i]), 32'(mem[i]), 32'(mc[i][6:4]));
      check($sformatf("ex_bc%0d", bc[i]), 32'(ex[i]), 32'(mc[i][3:0]));
      check($sformatf("valid_bc%0d", bc[i]), 32'(vo[i]), 32'(mv[i]));
      check($sformatf("bubble_bc%0d", bc[i]), 32'(bo[i]), 32'(mb[i]));
`ifdef IDEX_STATS_EN
      check($sformatf("cnt_bc%0d", bc[i]), 32'(cnt[i]), 32'(mcnt[i]));
`endif
    end
  endtask
  initial begin
    rst = 1'b1; ctrl = '0; valid = 1'b0; hd = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; mcnt[i] = 0; mc[i] = '0; mv[i] = 1'b0; mb[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(1, 9'h000, 0, 0, 0, 0);
    step(0, 9'h1A5, 1, 0, 0, 0);
    step(0, 9'h1FF, 1, 1, 0, 0);
    repeat (4) step(0, 9'h1FF, 1, 0, 0, 0);
    step(0, 9'h0F3, 1, 1, 0, 0);
    step(0, 9'h0F3, 1, 0, 0, 0);
    step(0, 9'h0F3, 1, 1, 1, 0);
    repeat (3) step(0, 9'h0F3, 1, 0, 0, 0);
    step(0, 9'h155, 1, 1, 0, 0);
    step(0, 9'h155, 1, 0, 0, 1);
    repeat (2) step(0, 9'h0AA, 1, 0, 0, 0);
    step(0, 9'h13C, 1, 1, 0, 1);
    step(0, 9'h13C, 0, 1, 0, 0);
    step(0, 9'h13C, 1, 0, 0, 0);
    step(0, 9'h1C3, 1, 1, 0, 0);
    step(1, 9'h1C3, 1, 0, 0, 0);
    step(0, 9'h1C3, 1, 0, 0, 0);
    repeat (40) step(0, 9'h101, 1, 1, 0, 0);
    step(0, 9'h101, 1, 0, 0, 1);
    step(0, 9'h066, 1, 0, 0, 0);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(63) == 0, 9'($urandom), $urandom_range(3) != 0, $urandom_range(3) == 0,
           $urandom_range(7) == 0, $urandom_range(15) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
